wfifo_burst_arb: RTL and testbench
==================================

# wfifo_burst_arb

Write-side burst arbiter sharing one asynchronous FIFO (via `gen_fifo_async_ctl`) among NREQ requesters in the wclk domain. It grants a whole burst only when the FIFO has space for every beat, based on the write-side depth. Beats from the owner are then steered onto the FIFO `push` port and RAM write data bus. It sits between the AHB-slave write channels and the XSPI TX FIFO.

## Interface
- `NREQ`, default 2: number of requesters (2..8).
- `PTR_WIDTH`, default 3: FIFO pointer width; must match the FIFO controller. Depth is 2^PTR_WIDTH.
- `DATA_W`, default 32: beat data width.
- `LEN_W`, default 3: burst length field width (beats-1). Must satisfy LEN_W <= PTR_WIDTH.

Ports:
- `wclk`  in  1: write clock.
- `wreset`  in  1: reset. Synchronous, active-high.
- `req`  in  NREQ: per-requester burst request, level.
- `req_len`  in  NREQ*LEN_W: per-requester burst length minus 1; slice i belongs to requester i.
- `req_valid`  in  NREQ: per-requester beat valid.
- `req_data`  in  NREQ*DATA_W: per-requester beat data.
- `wdepth`  in  PTR_WIDTH+1: FIFO depth as seen on the write side.
- `full`  in  1: FIFO full.
- `gnt`  out  NREQ: one-hot burst grant, registered.
- `beat_rdy`  out  NREQ: beat accepted this cycle; equals `gnt` & `req_valid` & ~`full`.
- `push`  out  1: FIFO push.
- `push_data`  out  DATA_W (+ID_W with tag): write data to the RAM at `ram_write_addr`.
- `busy`  out  1: a burst is in progress.

## Operation
- FSM states are IDLE and XFER.
- **IDLE:**
  - space = 2^PTR_WIDTH − wdepth, width PTR_WIDTH+1, no wrap possible.
  - Candidate i is eligible when req[i] & (req_len[i]+1 <= space). Compare at PTR_WIDTH+1 bits.
  - Round-robin selects among eligible candidates, starting at rr_ptr.
  - On a winner w: gnt <= onehot(w), beat_cnt <= req_len[w], rr_ptr <= w+1 mod NREQ, next state XFER.
  - If no candidate is eligible, stay in IDLE. An ineligible requester does not block others.
- **XFER:**
  - push = req_valid[w] & ~full; push_data = req_data[w].
  - Each push decrements beat_cnt.
  - A push with beat_cnt==0 is the last beat: gnt <= 0 and the FSM returns to IDLE next cycle.
  - A lower wdepth from reads during XFER has no effect on the burst.
- The `full` gating is defensive only; the space check guarantees `full` is never seen in XFER with conforming inputs.
- Requester rules:
  - Hold req and req_len stable from assertion until gnt.
  - Keeping req high after the last beat requests another burst; it is re-arbitrated normally.
  - Dropping req during XFER does not abort the burst. The arbiter waits for all beats.
- **wreset:** state IDLE, gnt=0, push=0, beat_rdy=0, busy=0, beat_cnt=0, rr_ptr=0. It takes effect at the next edge, mid-burst included, and partial beats are discarded. FIFO flush is the system's responsibility.

## Timing
- Grant latency: req high with enough space in IDLE at edge k gives gnt high after edge k. The first beat can push in cycle k+1.
- Throughput is 1 beat/cycle when req_valid is held high. A burst of L+1 beats occupies L+1 XFER cycles.
- There is exactly 1 IDLE bubble cycle between consecutive bursts.
- push, beat_rdy and push_data are combinational from registered state and inputs. All other outputs are registered.
- busy = (state==XFER).

## Configuration
- `WFIFO_ARB_TAG_EN`
  - Defined: push_data = {owner_id, req_data[w]} with ID_W = clog2(NREQ) (min 1), so the read side can demultiplex beats. The FIFO RAM must be DATA_W+ID_W wide.
  - Undefined: push_data = req_data[w], width DATA_W.

## Structure
- Package `wfifo_arb_pkg` holds:
  - the state enum (IDLE, XFER);
  - a clog2-based ID_W function;
  - the localparam DEPTH = 1<<PTR_WIDTH helper.
- Sub-module `wfifo_rr_arb`: combinational NREQ-way round-robin. Inputs are eligible vector and rr_ptr; outputs are one-hot winner and a valid flag.
- The top level holds the FSM, beat counter, space check and data mux.

## Test plan
- Single requester, PTR_WIDTH=3, wdepth=0, req_len=3, valid held high: gnt0 one cycle after req, 4 consecutive pushes, then gnt=0 and busy=0.
- wdepth=6, req0 len=3 and req1 len=1: req1 granted first. req0 is granted only after wdepth <= 4.
- Both requesters continuous, len=1, ample space: grants alternate 0,1,0,1 with one bubble cycle each; rr_ptr wraps correctly.
- req_valid toggled 1,0,1,0 in XFER: pushes only in valid cycles, beat_cnt exact, no extra push.
- wreset asserted on the 2nd beat of a 4-beat burst: the next cycle shows gnt=0, push=0, busy=0; the following grant goes to req0.
- With `WFIFO_ARB_TAG_EN`, NREQ=4: beats from requester 2 carry ID 2'b10 in the MSBs of push_data.

Source files
------------

// File: rtl/wfifo_arb_pkg.sv
// Shared state type and sizing helpers for the write-side FIFO burst arbiter.
package wfifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Owner-id width; a single requester still needs one bit of id.
  function automatic int id_w(input int nreq);
    if (nreq > 2) begin
      return $clog2(nreq);
    end else begin
      return 1;
    end
  endfunction

  function automatic int fifo_depth(input int ptr_width);
    return 1 << ptr_width;
  endfunction

endpackage

// File: rtl/wfifo_rr_arb.sv
// Combinational NREQ-way round-robin picker: first eligible requester at or after rr_ptr wins.
module wfifo_rr_arb
  import wfifo_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  winner,
  output logic             win_valid
);

  int               pos_s;
  logic [IDX_W-1:0] sel_s;

  // Scan once around the ring starting at rr_ptr, keeping the first hit
  always_comb begin
    winner    = '0;
    win_valid = 1'b0;
    pos_s     = 0;
    sel_s     = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos_s = int'(rr_ptr) + k;
      if (pos_s >= NREQ) begin
        pos_s = pos_s - NREQ;
      end else begin
        pos_s = pos_s;
      end
      sel_s = IDX_W'(pos_s);
      if (!win_valid && eligible[sel_s]) begin
        winner[sel_s] = 1'b1;
        win_valid     = 1'b1;
      end else begin
        win_valid = win_valid;
      end
    end
  end

endmodule

// File: rtl/wfifo_burst_arb.sv
// Write-side burst arbiter: grants a whole burst only when the async FIFO has room for every beat.
// Optional WFIFO_ARB_TAG_EN prepends the owner id to push_data so the read side can demultiplex.
module wfifo_burst_arb
  import wfifo_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int PTR_WIDTH = 3,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 3,
  localparam int ID_W     = id_w(NREQ),
`ifdef WFIFO_ARB_TAG_EN
  localparam int PD_W     = DATA_W + ID_W
`else
  localparam int PD_W     = DATA_W
`endif
) (
  input  logic                     wclk,
  input  logic                     wreset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*LEN_W-1:0]    req_len,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [PTR_WIDTH:0]       wdepth,
  input  logic                     full,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          beat_rdy,
  output logic                     push,
  output logic [PD_W-1:0]          push_data,
  output logic                     busy
);

  localparam int              SPW     = PTR_WIDTH + 1;
  localparam int              DEPTH   = fifo_depth(PTR_WIDTH);
  localparam logic [SPW-1:0]  DEPTH_V = SPW'(DEPTH);

  arb_state_e        state_r, state_nxt;
  logic [NREQ-1:0]   gnt_r, gnt_nxt;
  logic [LEN_W-1:0]  cnt_r, cnt_nxt;
  logic [ID_W-1:0]   rr_r, rr_nxt;
  logic [ID_W-1:0]   owner_r, owner_nxt;

  logic [SPW-1:0]    space_s;
  logic [NREQ-1:0]   elig_s, win_s;
  logic              win_valid_s;
  logic [ID_W-1:0]   win_idx_s, rr_wrap_s;
  logic              push_s;
  logic [LEN_W-1:0]  len_a  [NREQ];
  logic [DATA_W-1:0] data_a [NREQ];

  // Unpack requester fields; a burst is eligible only if all its beats fit in free space
  always_comb begin
    space_s = DEPTH_V - wdepth;
    for (int i = 0; i < NREQ; i++) begin
      len_a[i]  = req_len[i*LEN_W +: LEN_W];
      data_a[i] = req_data[i*DATA_W +: DATA_W];
      elig_s[i] = req[i] && ((SPW'(len_a[i]) + SPW'(1)) <= space_s);
    end
  end

  wfifo_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (ID_W)
  ) u_rr (
    .eligible  (elig_s),
    .rr_ptr    (rr_r),
    .winner    (win_s),
    .win_valid (win_valid_s)
  );

  // Encode the one-hot winner and the pointer position just after it
  always_comb begin
    win_idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_s[i]) begin
        win_idx_s = ID_W'(i);
      end else begin
        win_idx_s = win_idx_s;
      end
    end
    if (int'(win_idx_s) == NREQ - 1) begin
      rr_wrap_s = '0;
    end else begin
      rr_wrap_s = win_idx_s + ID_W'(1);
    end
  end

  assign push_s = (state_r == XFER) && req_valid[owner_r] && !full;

  // Next-state: grant in IDLE, count beats in XFER, release on the last pushed beat
  always_comb begin
    state_nxt = state_r;
    gnt_nxt   = gnt_r;
    cnt_nxt   = cnt_r;
    rr_nxt    = rr_r;
    owner_nxt = owner_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          state_nxt = XFER;
          gnt_nxt   = win_s;
          cnt_nxt   = len_a[win_idx_s];
          rr_nxt    = rr_wrap_s;
          owner_nxt = win_idx_s;
        end else begin
          state_nxt = IDLE;
        end
      end
      XFER: begin
        if (push_s && (cnt_r == '0)) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end else if (push_s) begin
          cnt_nxt = cnt_r - LEN_W'(1);
        end else begin
          state_nxt = XFER;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register; reset abandons any partial burst
  always_ff @(posedge wclk) begin
    if (wreset) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      cnt_r   <= '0;
      rr_r    <= '0;
      owner_r <= '0;
    end else begin
      state_r <= state_nxt;
      gnt_r   <= gnt_nxt;
      cnt_r   <= cnt_nxt;
      rr_r    <= rr_nxt;
      owner_r <= owner_nxt;
    end
  end

  // Beat steering from the registered owner; full gating is purely defensive
  always_comb begin
    push     = push_s;
    beat_rdy = gnt_r & req_valid & {NREQ{~full}};
`ifdef WFIFO_ARB_TAG_EN
    push_data = {owner_r, data_a[owner_r]};
`else
    push_data = data_a[owner_r];
`endif
  end

  assign gnt  = gnt_r;
  assign busy = (state_r == XFER);

endmodule

// File: tb/tb_wfifo_burst_arb.sv
// Scoreboard bench for wfifo_burst_arb: planned grants and beats are queued, a negedge monitor checks them.
module tb_wfifo_burst_arb;

`ifdef WFIFO_ARB_TAG_EN
  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int PD_W = 32 + ID_W;
`else
  localparam int NREQ = 2;
  localparam int PD_W = 32;
`endif
  localparam int PTR_WIDTH = 3;
  localparam int DATA_W    = 32;
  localparam int LEN_W     = 3;

  logic                   wclk = 1'b0;
  logic                   wreset;
  logic [NREQ-1:0]        req;
  logic [NREQ*LEN_W-1:0]  req_len;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [PTR_WIDTH:0]     wdepth;
  logic                   full;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        beat_rdy;
  logic                   push;
  logic [PD_W-1:0]        push_data;
  logic                   busy;

  int total = 0;
  int bad   = 0;
  logic [PD_W-1:0] exp_q[$];
  logic [NREQ-1:0] gnt_q[$];
  int src_cnt  [NREQ] = '{default: 0};
  int plan_cnt [NREQ] = '{default: 0};
  logic [NREQ-1:0] prev_gnt = '0;
  int t3_gnt [12] = '{1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0};
  logic t4_v [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  wfifo_burst_arb #(
    .NREQ(NREQ), .PTR_WIDTH(PTR_WIDTH), .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) dut (
    .wclk(wclk), .wreset(wreset), .req(req), .req_len(req_len),
    .req_valid(req_valid), .req_data(req_data), .wdepth(wdepth), .full(full),
    .gnt(gnt), .beat_rdy(beat_rdy), .push(push), .push_data(push_data), .busy(busy)
  );

  always #5 wclk = ~wclk;

  function automatic logic [DATA_W-1:0] beat_word(input int i, input int n);
    return {8'(i), 8'h5A, 16'(n)};
  endfunction

  function automatic logic [PD_W-1:0] exp_word(input int i, input int n);
`ifdef WFIFO_ARB_TAG_EN
    return {ID_W'(i), beat_word(i, n)};
`else
    return beat_word(i, n);
`endif
  endfunction

  // Requester model: each source advances to its next beat once the arbiter accepts one
  always @(posedge wclk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (beat_rdy[i] === 1'b1) src_cnt[i] <= src_cnt[i] + 1;
    end
  end

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*DATA_W +: DATA_W] = beat_word(i, src_cnt[i]);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_len(input int i, input int l);
    req_len[i*LEN_W +: LEN_W] = LEN_W'(l);
  endtask

  task automatic plan(input int i, input int len);
    gnt_q.push_back(NREQ'(1) << i);
    for (int b = 0; b <= len; b++) begin
      exp_q.push_back(exp_word(i, plan_cnt[i]));
      plan_cnt[i]++;
    end
  endtask

  task automatic do_reset();
    wreset = 1'b1;
    tick();
    wreset = 1'b0;
  endtask

  // Monitor: every push must match the next planned beat, every new grant the next planned owner
  always @(negedge wclk) begin
    if (push === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL push_data: unexpected push of %0h", push_data);
      end else begin
        chk("push_data", 64'(push_data), 64'(exp_q.pop_front()));
      end
    end
    if ((gnt !== '0) && (prev_gnt === '0)) begin
      if (gnt_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL grant_order: unexpected grant %0h", gnt);
      end else begin
        chk("grant_order", 64'(gnt), 64'(gnt_q.pop_front()));
      end
    end
    prev_gnt <= gnt;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    wreset = 1'b1; req = '0; req_valid = '1; req_len = '0; wdepth = '0; full = 1'b0;
    tick(); tick();
    @(negedge wclk);
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_push", 64'(push), 64'(0));
    chk("rst_beat_rdy", 64'(beat_rdy), 64'(0));

    // single requester, 4-beat burst, back-to-back pushes
    tick(); wreset = 1'b0; set_len(0, 3); plan(0, 3); req[0] = 1'b1;
    tick();
    @(negedge wclk);
    chk("t1_gnt", 64'(gnt), 64'(1));
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_push0", 64'(push), 64'(1));
    tick(); req[0] = 1'b0;
    @(negedge wclk); chk("t1_push1", 64'(push), 64'(1));
    for (int k = 2; k < 4; k++) begin
      tick();
      @(negedge wclk); chk("t1_pushn", 64'(push), 64'(1));
    end
    tick();
    @(negedge wclk);
    chk("t1_end_gnt", 64'(gnt), 64'(0));
    chk("t1_end_busy", 64'(busy), 64'(0));
    chk("t1_end_push", 64'(push), 64'(0));

    // space check: only the 2-beat burst fits until wdepth drops to 4
    tick(); do_reset();
    wdepth = 4'd6; set_len(0, 3); set_len(1, 1); plan(1, 1); req[0] = 1'b1; req[1] = 1'b1;
    tick();
    @(negedge wclk); chk("t2_gnt1", 64'(gnt), 64'(2));
    tick(); req[1] = 1'b0;
    tick();
    @(negedge wclk); chk("t2_idle", 64'(gnt), 64'(0));
    repeat (3) tick();
    @(negedge wclk); chk("t2_blocked", 64'(gnt), 64'(0));
    tick(); wdepth = 4'd4; plan(0, 3);
    tick();
    @(negedge wclk); chk("t2_gnt0", 64'(gnt), 64'(1));
    tick(); req[0] = 1'b0;
    repeat (3) tick();
    @(negedge wclk); chk("t2_done", 64'(busy), 64'(0));

    // both continuous: alternating grants with one bubble between bursts
    tick(); do_reset();
    wdepth = '0; set_len(0, 1); set_len(1, 1);
    plan(0, 1); plan(1, 1); plan(0, 1); plan(1, 1);
    req[0] = 1'b1; req[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 10) req = '0;
      @(negedge wclk); chk("t3_gnt_seq", 64'(gnt), 64'(t3_gnt[k]));
    end
    tick();

    // req_valid gaps during a burst
    tick(); set_len(0, 3); plan(0, 3); req[0] = 1'b1; req_valid[0] = 1'b1;
    tick(); req[0] = 1'b0;
    @(negedge wclk);
    chk("t4_gnt", 64'(gnt), 64'(1));
    chk("t4_push0", 64'(push), 64'(1));
    for (int k = 0; k < 6; k++) begin
      tick(); req_valid[0] = t4_v[k];
      @(negedge wclk);
      chk("t4_push_gap", 64'(push), 64'(t4_v[k]));
      chk("t4_beat_rdy", 64'(beat_rdy[0]), 64'(t4_v[k]));
    end
    tick();
    @(negedge wclk);
    chk("t4_no_extra", 64'(push), 64'(0));
    chk("t4_busy", 64'(busy), 64'(0));

    // reset on the second beat of a 4-beat burst
    tick(); set_len(0, 3); plan(0, 3); req[0] = 1'b1;
    tick(); req[0] = 1'b0;
    tick(); wreset = 1'b1;
    @(negedge wclk); chk("t5_beat2", 64'(push), 64'(1));
    tick();
    @(negedge wclk);
    chk("t5_rst_gnt", 64'(gnt), 64'(0));
    chk("t5_rst_push", 64'(push), 64'(0));
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_rdy", 64'(beat_rdy), 64'(0));
    exp_q.delete(); gnt_q.delete();
    for (int i = 0; i < NREQ; i++) plan_cnt[i] = src_cnt[i];
    tick(); wreset = 1'b0; set_len(0, 1); set_len(1, 1); plan(0, 1); req[0] = 1'b1; req[1] = 1'b1;
    tick(); req = '0;
    @(negedge wclk); chk("t5_regrant", 64'(gnt), 64'(1));
    tick(); tick();
    @(negedge wclk); chk("t5_done", 64'(busy), 64'(0));

`ifdef WFIFO_ARB_TAG_EN
    tick(); set_len(2, 0); plan(2, 0); req[2] = 1'b1;
    tick(); req[2] = 1'b0;
    @(negedge wclk);
    chk("tag_gnt", 64'(gnt), 64'(4));
    chk("tag_id", 64'(push_data[PD_W-1 -: 2]), 64'(2'b10));
    tick();
    @(negedge wclk); chk("tag_done", 64'(busy), 64'(0));
`endif

    tick();
    @(negedge wclk);
    chk("beats_left", 64'(exp_q.size()), 64'(0));
    chk("grants_left", 64'(gnt_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
